// File: rtl/racket_control_if.sv
// Signal bundle between the frame/button sources and the racket controller.
// Handshake: none. Every input is level-sampled on clk65MHz, end_of_frame is a
// one-cycle tick, and serve is a one-cycle output pulse. There is no backpressure.
interface racket_control_if;
   logic        end_of_frame;
   logic        btn_p1_up;
   logic        btn_p1_down;
   logic        btn_p2_up;
   logic        btn_p2_down;
   logic        btn_serve;
   logic        screen_idle;
   logic        screen_multi;
   logic [10:0] y_pos_of_ball;
   logic [9:0]  pos_of_player_1;
   logic [9:0]  pos_of_player_2;
   logic        serve;

   modport master (
      output end_of_frame, btn_p1_up, btn_p1_down, btn_p2_up, btn_p2_down,
             btn_serve, screen_idle, screen_multi, y_pos_of_ball,
      input  pos_of_player_1, pos_of_player_2, serve
   );

   modport slave (
      input  end_of_frame, btn_p1_up, btn_p1_down, btn_p2_up, btn_p2_down,
             btn_serve, screen_idle, screen_multi, y_pos_of_ball,
      output pos_of_player_1, pos_of_player_2, serve
   );
endinterface

// File: rtl/racket_control.sv
// Racket controller: synchronises and debounces the raw buttons, produces a
// one-cycle serve pulse, and updates both racket positions once per frame.
// Player 2 is a ball-tracking CPU racket when screen_multi is low.
module racket_control #(
   parameter int DEBOUNCE_CYCLES = 650000,
   parameter int Y_MIN           = 51,
   parameter int Y_MAX           = 637,
   parameter int SPEED_MIN       = 4,
   parameter int SPEED_MAX       = 16,
   parameter int CPU_SPEED       = 6
) (
   input logic              clk65MHz,
   input logic              rst_n,
   racket_control_if.slave  bus
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0]     CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [9:0]        POS_CENTRE = 10'((Y_MIN + Y_MAX) / 2);
   localparam logic [4:0]        SPD_MIN    = 5'(SPEED_MIN);
   localparam logic [4:0]        SPD_MAX    = 5'(SPEED_MAX);
   localparam logic signed [12:0] Y_MIN_S   = 13'(Y_MIN);
   localparam logic signed [12:0] Y_MAX_S   = 13'(Y_MAX);
   localparam logic signed [12:0] CPU_S     = 13'(CPU_SPEED);

   typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_UP = 2'd1, DIR_DOWN = 2'd2} dir_t;

   // Per-racket state: position, speed for the next frame, last frame's direction.
   typedef struct packed {
      logic [9:0] pos;
      logic [4:0] speed;
      dir_t       dir;
   } motion_t;

   localparam motion_t MOTION_RST = '{pos: POS_CENTRE, speed: SPD_MIN, dir: DIR_NONE};

   // Button order: {serve, p2_down, p2_up, p1_down, p1_up}.
   logic [4:0]          w_btn_raw;
   logic [4:0]          r_sync1;
   logic [4:0]          r_sync2;
   logic [4:0]          r_stable;
   logic [4:0][CW-1:0]  r_cnt;
   logic                w_serve_rise;
   logic                r_serve;
   motion_t             r_p1;
   motion_t             r_p2;
   motion_t             w_p1_next;
   motion_t             w_p2_human;
   motion_t             w_p2_cpu;

   assign w_btn_raw = {bus.btn_serve, bus.btn_p2_down, bus.btn_p2_up,
                       bus.btn_p1_down, bus.btn_p1_up};

   function automatic logic [9:0] clamp_pos(input logic signed [12:0] v);
      if (v < Y_MIN_S)      clamp_pos = 10'(Y_MIN);
      else if (v > Y_MAX_S) clamp_pos = 10'(Y_MAX);
      else                  clamp_pos = 10'(v);
   endfunction

   // Human racket: step restarts at SPEED_MIN on any direction change and
   // grows by one per held frame up to SPEED_MAX.
   function automatic motion_t human_step(input motion_t cur, input logic up, input logic dn);
      motion_t           n;
      dir_t              d;
      logic [4:0]        step;
      logic signed [12:0] p;
      logic signed [12:0] s;
      n    = cur;
      step = '0;
      if (up && !dn)      d = DIR_UP;
      else if (dn && !up) d = DIR_DOWN;
      else                d = DIR_NONE;
      if (d == DIR_NONE) begin
         n.speed = SPD_MIN;
      end else if (d != cur.dir) begin
         step    = SPD_MIN;
         n.speed = SPD_MIN + 5'd1;
      end else begin
         step    = cur.speed;
         n.speed = (cur.speed >= SPD_MAX) ? SPD_MAX : cur.speed + 5'd1;
      end
      n.dir = d;
      p     = $signed({3'b000, cur.pos});
      s     = $signed({8'b0, step});
      n.pos = clamp_pos((d == DIR_UP) ? p - s : p + s);
      return n;
   endfunction

   // CPU racket: move toward the clamped ball-centre target without overshoot.
   function automatic motion_t cpu_step(input motion_t cur, input logic [10:0] ball);
      motion_t            n;
      logic [9:0]         target;
      logic signed [12:0] p;
      logic signed [12:0] diff;
      target  = clamp_pos($signed({2'b00, ball}) + 13'sd7 - 13'sd40);
      p       = $signed({3'b000, cur.pos});
      diff    = $signed({3'b000, target}) - p;
      n.speed = SPD_MIN;
      n.dir   = DIR_NONE;
      if (diff > CPU_S)       n.pos = clamp_pos(p + CPU_S);
      else if (diff < -CPU_S) n.pos = clamp_pos(p - CPU_S);
      else                    n.pos = target;
      return n;
   endfunction

   // Serve rises on the exact cycle the debounced serve flips from 0 to 1.
   assign w_serve_rise = r_sync2[4] && !r_stable[4] && (r_cnt[4] == CNT_LAST);

   // Two-flop synchronisers and per-button debounce counters.
   always_ff @(posedge clk65MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_stable <= '0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
         for (int i = 0; i < 5; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_cnt[i]    <= '0;
               r_stable[i] <= r_sync2[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Serve pulse register, held low on the menu screen.
   always_ff @(posedge clk65MHz or negedge rst_n) begin
      if (!rst_n) r_serve <= 1'b0;
      else        r_serve <= w_serve_rise && !bus.screen_idle;
   end

   // Next-frame candidates for each racket.
   always_comb begin
      w_p1_next  = human_step(r_p1, r_stable[0], r_stable[1]);
      w_p2_human = human_step(r_p2, r_stable[2], r_stable[3]);
      w_p2_cpu   = cpu_step(r_p2, bus.y_pos_of_ball);
   end

   // Racket state: idle recentres immediately, otherwise update on the frame tick.
   always_ff @(posedge clk65MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_p1 <= MOTION_RST;
         r_p2 <= MOTION_RST;
      end else if (bus.screen_idle) begin
         r_p1 <= MOTION_RST;
         r_p2 <= MOTION_RST;
      end else if (bus.end_of_frame) begin
         r_p1 <= w_p1_next;
         r_p2 <= bus.screen_multi ? w_p2_human : w_p2_cpu;
      end
   end

   assign bus.pos_of_player_1 = r_p1.pos;
   assign bus.pos_of_player_2 = r_p2.pos;
   assign bus.serve           = r_serve;

endmodule

// File: tb/tb_racket_control.sv
// Bench for racket_control with an 8-cycle debounce.
module tb_racket_control;

   typedef struct {
      logic       u1, d1, u2, d2;
      logic [9:0] e1, e2;
   } vec_t;

   logic clk65MHz;
   logic rst_n;
   int   checks;
   int   failures;
   int   serve_cnt;
   logic [9:0] exp_q[$];
   vec_t tab[28];

   racket_control_if bus();

   racket_control #(.DEBOUNCE_CYCLES(8)) dut (
      .clk65MHz (clk65MHz),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   // Clock and serve pulse counter.
   initial clk65MHz = 1'b0;
   always #5 clk65MHz = ~clk65MHz;

   always @(negedge clk65MHz) if (bus.serve === 1'b1) serve_cnt++;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic set_btns(input logic u1, input logic d1, input logic u2, input logic d2);
      @(negedge clk65MHz);
      bus.btn_p1_up   = u1;
      bus.btn_p1_down = d1;
      bus.btn_p2_up   = u2;
      bus.btn_p2_down = d2;
      repeat (12) @(negedge clk65MHz);
   endtask

   // One end_of_frame tick, no checks.
   task automatic tick();
      @(negedge clk65MHz);
      bus.end_of_frame = 1'b1;
      @(negedge clk65MHz);
      bus.end_of_frame = 1'b0;
   endtask

   // One frame tick with positions checked against the scoreboard.
   task automatic tick_check(input string name);
      int e1, e2;
      @(negedge clk65MHz);
      bus.end_of_frame = 1'b1;
      @(posedge clk65MHz);
      #1;
      e1 = int'(exp_q.pop_front());
      e2 = int'(exp_q.pop_front());
      check({name, "_p1"}, int'(bus.pos_of_player_1), e1);
      check({name, "_p2"}, int'(bus.pos_of_player_2), e2);
      @(negedge clk65MHz);
      bus.end_of_frame = 1'b0;
      @(posedge clk65MHz);
      #1;
      check({name, "_hold"}, int'(bus.pos_of_player_1), e1);
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      set_btns(v.u1, v.d1, v.u2, v.d2);
      exp_q.push_back(v.e1);
      exp_q.push_back(v.e2);
      tick_check($sformatf("vec%0d", idx));
   endtask

   task automatic press_serve(input int hold);
      @(negedge clk65MHz);
      bus.btn_serve = 1'b1;
      repeat (hold) @(negedge clk65MHz);
      bus.btn_serve = 1'b0;
      repeat (30) @(negedge clk65MHz);
   endtask

   initial begin
      int lat;
      int min_pos;
      checks = 0; failures = 0; serve_cnt = 0;
      // acceleration, direction changes, both-pressed
      tab[0]  = '{0,1,1,0,348,340};
      tab[1]  = '{0,1,1,0,353,335};
      tab[2]  = '{0,1,1,0,359,329};
      tab[3]  = '{0,1,0,1,366,333};
      tab[4]  = '{0,1,0,1,374,338};
      tab[5]  = '{0,0,0,0,374,338};
      tab[6]  = '{0,1,0,0,378,338};
      tab[7]  = '{1,1,1,1,378,338};
      tab[8]  = '{1,0,0,1,374,342};
      tab[9]  = '{0,1,0,0,378,342};
      // top clamp
      tab[10] = '{0,1,0,0,55,342};
      tab[11] = '{0,1,0,0,60,342};
      tab[12] = '{0,0,0,0,60,342};
      tab[13] = '{1,0,0,0,56,342};
      tab[14] = '{1,0,0,0,51,342};
      tab[15] = '{1,0,0,0,51,342};
      // bottom clamp
      tab[16] = '{1,0,0,0,633,342};
      tab[17] = '{1,0,0,0,628,342};
      tab[18] = '{1,0,0,0,622,342};
      tab[19] = '{1,0,0,0,615,342};
      tab[20] = '{0,0,0,0,615,342};
      tab[21] = '{0,1,0,0,619,342};
      tab[22] = '{0,1,0,0,624,342};
      tab[23] = '{0,1,0,0,630,342};
      tab[24] = '{0,0,0,0,630,342};
      tab[25] = '{0,1,0,0,634,342};
      tab[26] = '{0,1,0,0,637,342};
      tab[27] = '{0,1,0,0,637,342};

      rst_n = 1'b0;
      bus.end_of_frame = 1'b0; bus.btn_p1_up = 1'b0; bus.btn_p1_down = 1'b0;
      bus.btn_p2_up = 1'b0; bus.btn_p2_down = 1'b0; bus.btn_serve = 1'b0;
      bus.screen_idle = 1'b0; bus.screen_multi = 1'b1; bus.y_pos_of_ball = 11'd0;
      repeat (3) @(negedge clk65MHz);
      check("rst_p1", int'(bus.pos_of_player_1), 344);
      check("rst_p2", int'(bus.pos_of_player_2), 344);
      check("rst_serve", int'(bus.serve), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk65MHz);

      // Serve: glitch, clean press with latency, second press, idle suppression.
      press_serve(5);
      check("serve_glitch", serve_cnt, 0);
      @(negedge clk65MHz);
      bus.btn_serve = 1'b1;
      exp_q.push_back(10'd10);
      lat = -1;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk65MHz);
         #1;
         if (bus.serve === 1'b1 && lat < 0) lat = c;
      end
      check("serve_latency", lat, int'(exp_q.pop_front()));
      check("serve_single", serve_cnt, 1);
      @(negedge clk65MHz);
      bus.btn_serve = 1'b0;
      repeat (20) @(negedge clk65MHz);
      press_serve(40);
      check("serve_second", serve_cnt, 2);
      bus.screen_idle = 1'b1;
      press_serve(40);
      check("serve_idle", serve_cnt, 2);
      bus.screen_idle = 1'b0;

      for (int i = 0; i <= 8; i++) apply_vec(tab[i], i);

      // No frame tick for 1000 cycles with a button held.
      set_btns(0, 1, 0, 0);
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk65MHz);
         if (c % 100 == 99) begin
            check("noframe_p1", int'(bus.pos_of_player_1), 374);
            check("noframe_p2", int'(bus.pos_of_player_2), 342);
         end
      end
      apply_vec(tab[9], 9);

      // Drive to the top limit; never pass it.
      set_btns(1, 0, 0, 0);
      min_pos = 1000;
      for (int f = 0; f < 40; f++) begin
         tick();
         if (int'(bus.pos_of_player_1) < min_pos) min_pos = int'(bus.pos_of_player_1);
      end
      check("top_min", min_pos, 51);
      check("top_pos", int'(bus.pos_of_player_1), 51);
      for (int i = 10; i <= 15; i++) apply_vec(tab[i], i);

      set_btns(0, 1, 0, 0);
      for (int f = 0; f < 50; f++) tick();
      check("bottom_pos", int'(bus.pos_of_player_1), 637);
      for (int i = 16; i <= 27; i++) apply_vec(tab[i], i);

      // Idle recentres on the next edge without a frame tick.
      set_btns(0, 0, 0, 0);
      @(negedge clk65MHz);
      bus.screen_idle = 1'b1;
      @(posedge clk65MHz);
      #1;
      check("idle_p1", int'(bus.pos_of_player_1), 344);
      check("idle_p2", int'(bus.pos_of_player_2), 344);
      @(negedge clk65MHz);
      bus.screen_idle = 1'b0;

      // CPU tracking with player-2 buttons pressed.
      bus.screen_multi = 1'b0;
      bus.y_pos_of_ball = 11'd500;
      set_btns(0, 0, 1, 0);
      for (int k = 1; k <= 25; k++) begin
         exp_q.push_back(10'd344);
         exp_q.push_back(10'((344 + 6 * k > 467) ? 467 : 344 + 6 * k));
         tick_check($sformatf("cpu%0d", k));
      end
      bus.y_pos_of_ball = 11'd10;
      exp_q.push_back(10'd344); exp_q.push_back(10'd461);
      tick_check("cpu_low1");
      exp_q.push_back(10'd344); exp_q.push_back(10'd455);
      tick_check("cpu_low2");

      // Back to two players: position continues from where the CPU left it.
      set_btns(0, 0, 0, 0);
      bus.screen_multi = 1'b1;
      exp_q.push_back(10'd344); exp_q.push_back(10'd455);
      tick_check("multi_cont");
      set_btns(0, 0, 0, 1);
      exp_q.push_back(10'd344); exp_q.push_back(10'd459);
      tick_check("multi_move");

      // Asynchronous reset mid-cycle, then three idle frames.
      @(negedge clk65MHz);
      #2;
      rst_n = 1'b0;
      bus.screen_idle = 1'b1;
      #1;
      check("async_rst_p1", int'(bus.pos_of_player_1), 344);
      check("async_rst_p2", int'(bus.pos_of_player_2), 344);
      check("async_rst_serve", int'(bus.serve), 0);
      repeat (2) @(negedge clk65MHz);
      rst_n = 1'b1;
      set_btns(0, 1, 1, 0);
      for (int f = 0; f < 3; f++) begin
         exp_q.push_back(10'd344); exp_q.push_back(10'd344);
         tick_check($sformatf("idle_frame%0d", f));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
